// File: rtl/io_image_scanner_pkg.sv
// Shared definitions for the scan sequencer and its physical I/O stage.
package io_image_scanner_pkg;

  // Phase encodings shared with the scan sequencer.
  typedef enum logic [1:0] {
    ST_OUT  = 2'b00,
    ST_PROG = 2'b01,
    ST_IN   = 2'b10,
    ST_INIT = 2'b11
  } phase_t;

  localparam int unsigned IMG_WORDS = 16;
  localparam int unsigned IDX_W     = 4;

endpackage

// File: rtl/io_image_scanner_io_sync.sv
// Two-flop synchroniser bank for asynchronous inputs, cleared by the async reset.
module io_sync #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/io_image_scanner.sv
// Physical I/O stage behind the scan sequencer: snapshots inputs into the input image,
// commits the output image to the pins in one update, and watches the PROG phase.
module io_image_scanner
  import io_image_scanner_pkg::*;
#(
  parameter int unsigned   DW       = 16,
  parameter int unsigned   N_WORDS  = IMG_WORDS,
  parameter logic [DW-1:0] OUT_SAFE = '0,
  parameter int unsigned   WDOG_W   = 20
) (
  input  logic                  CLK,
  input  logic                  CLR,
  input  logic [1:0]            STATE,
  input  logic [4:0]            COUNT,
  input  logic [N_WORDS*DW-1:0] IN_PINS,
  output logic                  IMG_WE,
  output logic [IDX_W-1:0]      IMG_ADDR,
  output logic [DW-1:0]         IMG_DIN,
  output logic [IDX_W-1:0]      OIMG_ADDR,
  input  logic [DW-1:0]         OIMG_DOUT,
  output logic [N_WORDS*DW-1:0] OUT_PINS,
  output logic                  OUT_UPD,
  output logic                  IN_CHANGED,
  output logic                  FAULT
);

  localparam int unsigned          PW       = N_WORDS * DW;
  localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(N_WORDS - 1);
  localparam logic [PW-1:0]        SAFE_IMG = {N_WORDS{OUT_SAFE}};
  localparam logic [N_WORDS-1:0]   LAST_BIT = N_WORDS'(1) << LAST_IDX;

  phase_t                      st;
  logic [IDX_W-1:0]            idx;
  logic                        unused_count_msb;
  logic [PW-1:0]               sync_q;
  logic [N_WORDS-1:0][DW-1:0]  snapshot;
  logic [N_WORDS-1:0][DW-1:0]  last_snapshot;
  logic [N_WORDS-1:0][DW-1:0]  staging;
  logic [N_WORDS-1:0][DW-1:0]  commit_img;
  logic                        in_prev;
  logic                        cap_valid;
  logic [IDX_W-1:0]            cap_idx;
  logic [N_WORDS-1:0]          cap_mask;
  logic                        commit;
  logic [WDOG_W-1:0]           wdog;
  logic                        fault_trip;

  assign st               = phase_t'(STATE);
  assign idx              = COUNT[IDX_W-1:0];
  assign unused_count_msb = COUNT[4];

  io_sync #(.W(PW)) u_sync (
    .clk   (CLK),
    .rst_n (CLR),
    .d     (IN_PINS),
    .q     (sync_q)
  );

  // Zero-latency image write path; the write strobe ignores WR_IMAGE on purpose.
  assign IMG_WE    = (st == ST_IN);
  assign IMG_ADDR  = idx;
  assign IMG_DIN   = snapshot[idx];
  assign OIMG_ADDR = idx;

  // Final word bypasses staging so the whole image lands in one update.
  always_comb begin
    commit_img          = staging;
    commit_img[cap_idx] = OIMG_DOUT;
    commit              = cap_valid && (cap_idx == LAST_IDX) && (&(cap_mask | LAST_BIT));
    fault_trip          = (st == ST_PROG) && (&wdog);
  end

  // Snapshot freezes for the whole IN phase so the image is coherent.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      snapshot      <= '0;
      last_snapshot <= '0;
      in_prev       <= 1'b0;
      IN_CHANGED    <= 1'b0;
    end else begin
      in_prev <= (st == ST_IN);
      if (st != ST_IN) begin
        snapshot <= sync_q;
      end
      if ((st == ST_IN) && !in_prev) begin
        IN_CHANGED    <= (snapshot != last_snapshot);
        last_snapshot <= snapshot;
      end
    end
  end

  // Capture pipeline tracks which words this OUT phase has delivered.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      cap_valid <= 1'b0;
      cap_idx   <= '0;
      cap_mask  <= '0;
      staging   <= '0;
    end else begin
      cap_valid <= (st == ST_OUT);
      cap_idx   <= idx;
      if (cap_valid) begin
        staging[cap_idx] <= OIMG_DOUT;
        if (commit) begin
          cap_mask <= '0;
        end else begin
          cap_mask[cap_idx] <= 1'b1;
        end
      end
    end
  end

  // Saturating PROG-phase watchdog with a sticky fault.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      wdog  <= '0;
      FAULT <= 1'b0;
    end else if (st == ST_PROG) begin
      if (&wdog) begin
        FAULT <= 1'b1;
      end else begin
        wdog <= wdog + WDOG_W'(1);
      end
    end else begin
      wdog <= '0;
    end
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      OUT_PINS <= SAFE_IMG;
      OUT_UPD  <= 1'b0;
    end else begin
      OUT_UPD <= commit;
      if (fault_trip) begin
        OUT_PINS <= SAFE_IMG;
      end else if (commit) begin
        OUT_PINS <= FAULT ? SAFE_IMG : commit_img;
      end
    end
  end

endmodule

// File: tb/tb_io_image_scanner.sv
// Self-checking bench for io_image_scanner: directed table rows, watchdog and reset
// sequences, then randomized scans against an image-level reference model.
module tb_io_image_scanner;
  import io_image_scanner_pkg::*;

  localparam int unsigned DW       = 16;
  localparam int unsigned NW       = 16;
  localparam int unsigned PW       = NW * DW;
  localparam int unsigned WDW      = 6;
  localparam int unsigned WD_LIMIT = 64;
  localparam logic [PW-1:0] SAFE   = '0;

  logic          CLK;
  logic          CLR;
  logic [1:0]    STATE;
  logic [4:0]    COUNT;
  logic [PW-1:0] IN_PINS;
  logic          IMG_WE;
  logic [3:0]    IMG_ADDR;
  logic [DW-1:0] IMG_DIN;
  logic [3:0]    OIMG_ADDR;
  logic [DW-1:0] OIMG_DOUT;
  logic [PW-1:0] OUT_PINS;
  logic          OUT_UPD;
  logic          IN_CHANGED;
  logic          FAULT;

  logic [DW-1:0] oram [NW];

  int checks = 0;
  int errors = 0;

  // Reference model state: expected pins, sticky fault, last IN-phase snapshot.
  logic [PW-1:0] cur_out;
  logic          cur_fault;
  logic [PW-1:0] model_last;

  typedef struct {
    logic [DW-1:0] in_base;
    logic [DW-1:0] in_w3;
    bit            flip;
    int            prog_len;
    logic [DW-1:0] out_base;
    int            out_len;
    bit            exp_chg;
    bit            exp_upd;
    logic [DW-1:0] exp_out_base;
  } row_t;

  row_t rows [5];

  io_image_scanner #(
    .DW       (DW),
    .N_WORDS  (NW),
    .OUT_SAFE ('0),
    .WDOG_W   (WDW)
  ) dut (
    .CLK        (CLK),
    .CLR        (CLR),
    .STATE      (STATE),
    .COUNT      (COUNT),
    .IN_PINS    (IN_PINS),
    .IMG_WE     (IMG_WE),
    .IMG_ADDR   (IMG_ADDR),
    .IMG_DIN    (IMG_DIN),
    .OIMG_ADDR  (OIMG_ADDR),
    .OIMG_DOUT  (OIMG_DOUT),
    .OUT_PINS   (OUT_PINS),
    .OUT_UPD    (OUT_UPD),
    .IN_CHANGED (IN_CHANGED),
    .FAULT      (FAULT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Output image RAM: synchronous read, one cycle of latency.
  always @(posedge CLK) OIMG_DOUT <= oram[OIMG_ADDR];

  task automatic chk(input string nm, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic logic [PW-1:0] img_seq(input logic [DW-1:0] base);
    logic [PW-1:0] v;
    for (int k = 0; k < NW; k++) v[k*DW +: DW] = base + DW'(k);
    return v;
  endfunction

  // Drive one sequencer cycle just after the edge; return mid-cycle for sampling.
  task automatic step(input logic [1:0] st, input int cnt);
    @(posedge CLK);
    #1;
    STATE = st;
    COUNT = 5'(cnt);
    @(negedge CLK);
  endtask

  task automatic do_prog(input int n);
    bit f;
    for (int j = 1; j <= n; j++) begin
      step(ST_PROG, j % 32);
      f = cur_fault || ((j - 1) >= WD_LIMIT);
      chk($sformatf("prog_fault[%0d]", j), PW'(FAULT), PW'(f));
      chk($sformatf("prog_pins[%0d]", j), OUT_PINS, f ? SAFE : cur_out);
      chk("prog_we", PW'(IMG_WE), PW'(0));
    end
    if (n >= WD_LIMIT) begin
      cur_fault = 1'b1;
      cur_out   = SAFE;
    end
  endtask

  task automatic do_out(input logic [PW-1:0] oimg, input int len);
    for (int k = 0; k < NW; k++) oram[k] = oimg[k*DW +: DW];
    for (int k = 0; k < len; k++) begin
      step(ST_OUT, k);
      chk("out_we", PW'(IMG_WE), PW'(0));
      chk($sformatf("oimg_addr[%0d]", k), PW'(OIMG_ADDR), PW'(k));
      if (k == 0) chk("out_pins_hold", OUT_PINS, cur_out);
    end
  endtask

  task automatic do_in(input logic [PW-1:0] exp_snap, input bit exp_chg, input bit exp_upd,
                       input logic [PW-1:0] exp_out, input bit flip, input int fw,
                       input logic [DW-1:0] fv, input int fat);
    for (int k = 0; k < NW; k++) begin
      step(ST_IN, k);
      chk("in_we", PW'(IMG_WE), PW'(1));
      chk($sformatf("img_addr[%0d]", k), PW'(IMG_ADDR), PW'(k));
      chk($sformatf("img_din[%0d]", k), PW'(IMG_DIN), PW'(exp_snap[k*DW +: DW]));
      if (k == 0) begin
        chk("pins_before_commit", OUT_PINS, cur_out);
        chk("upd_first_in", PW'(OUT_UPD), PW'(0));
      end
      if (k == 1) begin
        chk("upd_second_in", PW'(OUT_UPD), PW'(exp_upd));
        chk("pins_commit", OUT_PINS, exp_out);
        chk("in_changed", PW'(IN_CHANGED), PW'(exp_chg));
        chk("fault_in", PW'(FAULT), PW'(cur_fault));
      end
      if (k == 2) chk("upd_single_pulse", PW'(OUT_UPD), PW'(0));
      if (flip && k == fat) IN_PINS[fw*DW +: DW] = fv;
    end
    cur_out    = exp_out;
    model_last = exp_snap;
  endtask

  task automatic do_scan(input logic [PW-1:0] pins, input bit flip, input int fw,
                         input logic [DW-1:0] fv, input int fat, input int prog_len,
                         input logic [PW-1:0] oimg, input int out_len, input bit exp_chg,
                         input bit exp_upd, input logic [PW-1:0] exp_out);
    IN_PINS = pins;
    do_prog(prog_len);
    if (out_len > 0) do_out(oimg, out_len);
    do_in(pins, exp_chg, exp_upd, exp_out, flip, fw, fv, fat);
  endtask

  // Async reset mid-OUT at COUNT=9; the rest of that OUT phase must not commit.
  task automatic reset_mid_out(input logic [PW-1:0] oimg);
    for (int k = 0; k < NW; k++) oram[k] = oimg[k*DW +: DW];
    for (int k = 0; k < 10; k++) step(ST_OUT, k);
    #1;
    CLR = 1'b0;
    #1;
    chk("rst_pins", OUT_PINS, SAFE);
    chk("rst_fault", PW'(FAULT), PW'(0));
    chk("rst_upd", PW'(OUT_UPD), PW'(0));
    chk("rst_chg", PW'(IN_CHANGED), PW'(0));
    cur_out    = SAFE;
    cur_fault  = 1'b0;
    model_last = '0;
    #1;
    CLR = 1'b1;
    for (int k = 10; k < NW; k++) begin
      step(ST_OUT, k);
      chk("partial_upd", PW'(OUT_UPD), PW'(0));
    end
    do_in(IN_PINS, IN_PINS != '0, 1'b0, SAFE, 1'b0, 0, '0, 0);
  endtask

  initial begin
    logic [PW-1:0] pins;
    logic [PW-1:0] oimg;
    logic [PW-1:0] exp_out;
    int            out_len;
    bit            exp_upd;

    rows[0] = '{16'hA000, 16'hA003, 1'b0, 4, 16'h0F00, 16, 1'b1, 1'b1, 16'h0F00};
    rows[1] = '{16'hA000, 16'hA003, 1'b1, 6, 16'h2200, 16, 1'b0, 1'b1, 16'h2200};
    rows[2] = '{16'hA000, 16'h5555, 1'b0, 4, 16'h3300, 10, 1'b1, 1'b0, 16'h2200};
    rows[3] = '{16'hA000, 16'h5555, 1'b0, 5, 16'h4400, 16, 1'b0, 1'b1, 16'h4400};
    rows[4] = '{16'h1234, 16'h1237, 1'b0, 4, 16'h0000, 0,  1'b1, 1'b0, 16'h4400};

    cur_out    = SAFE;
    cur_fault  = 1'b0;
    model_last = '0;
    CLR        = 1'b0;
    STATE      = ST_INIT;
    COUNT      = '0;
    IN_PINS    = '0;
    for (int k = 0; k < NW; k++) oram[k] = '0;

    repeat (3) @(negedge CLK);
    chk("reset_pins", OUT_PINS, SAFE);
    chk("reset_upd", PW'(OUT_UPD), PW'(0));
    chk("reset_chg", PW'(IN_CHANGED), PW'(0));
    chk("reset_fault", PW'(FAULT), PW'(0));
    CLR = 1'b1;

    for (int k = 0; k < 32; k++) begin
      step(ST_INIT, k);
      chk("init_we", PW'(IMG_WE), PW'(0));
      chk("init_upd", PW'(OUT_UPD), PW'(0));
      chk("init_pins", OUT_PINS, SAFE);
    end

    for (int i = 0; i < 5; i++) begin
      pins = img_seq(rows[i].in_base);
      pins[3*DW +: DW] = rows[i].in_w3;
      do_scan(pins, rows[i].flip, 3, 16'h5555, 7, rows[i].prog_len,
              img_seq(rows[i].out_base), rows[i].out_len, rows[i].exp_chg,
              rows[i].exp_upd, img_seq(rows[i].exp_out_base));
    end

    // Watchdog trips after 2^WDOG_W PROG cycles; the next full OUT still commits safe.
    do_prog(WD_LIMIT + 2);
    do_out(img_seq(16'h5500), 16);
    do_in(IN_PINS, 1'b0, 1'b1, SAFE, 1'b0, 0, '0, 0);

    reset_mid_out(img_seq(16'h7700));
    do_scan(IN_PINS, 1'b0, 0, '0, 0, 4, img_seq(16'h6600), 16, 1'b0, 1'b1,
            img_seq(16'h6600));

    for (int r = 0; r < 20; r++) begin
      if ($urandom_range(0, 3) == 0) pins = model_last;
      else for (int k = 0; k < NW; k++) pins[k*DW +: DW] = DW'($urandom);
      for (int k = 0; k < NW; k++) oimg[k*DW +: DW] = DW'($urandom);
      out_len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : 16;
      exp_upd = (out_len == 16);
      exp_out = exp_upd ? (cur_fault ? SAFE : oimg) : cur_out;
      do_scan(pins, 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)), DW'($urandom),
              int'($urandom_range(0, 15)), 4 + int'($urandom_range(0, 16)), oimg, out_len,
              pins != model_last, exp_upd, exp_out);
    end

    reset_mid_out(img_seq(16'h8800));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/io_image_scanner.md
Name: io_image_scanner

Overview:
- Physical I/O stage directly downstream of the scan sequencer. It consumes the STATE and COUNT outputs of the sequencer.
- During IN it writes a frozen, synchronised snapshot of the physical inputs into the input image RAM, one word per cycle.
- During OUT it reads the output image RAM and commits all physical outputs in a single glitch-free update.
- A PROG-phase watchdog forces outputs to a safe value if the logic cores never finish.

Parameters:
- DW, 16, bits per image word.
- N_WORDS, 16, image words per scan; word index is COUNT[3:0].
- OUT_SAFE, 0, value driven on every output word at reset and on fault.
- WDOG_W, 20, watchdog counter width; fault when PROG lasts 2^WDOG_W cycles.

Ports:
- CLK  in  1  system clock.
- CLR  in  1  asynchronous active-low reset (0 = reset).
- STATE  in  2  sequencer phase: INIT=11, IN=10, PROG=01, OUT=00.
- COUNT  in  5  sequencer step counter; only [3:0] used.
- IN_PINS  in  N_WORDS*DW  raw asynchronous physical inputs; word k = bits [k*DW +: DW].
- IMG_WE  out  1  input image RAM write enable.
- IMG_ADDR  out  4  input image RAM address.
- IMG_DIN  out  DW  input image RAM write data.
- OIMG_ADDR  out  4  output image RAM read address (synchronous RAM, 1-cycle read latency).
- OIMG_DOUT  in  DW  output image RAM read data.
- OUT_PINS  out  N_WORDS*DW  registered physical outputs.
- OUT_UPD  out  1  one-cycle pulse when OUT_PINS is committed.
- IN_CHANGED  out  1  current input snapshot differs from the previous scan's snapshot.
- FAULT  out  1  sticky watchdog fault.

Behaviour:
- Reset (CLR=0, asynchronous) clears:
  - sync flops, snapshot, last_snapshot, staging and capture pipeline → 0;
  - OUT_PINS → OUT_SAFE;
  - OUT_UPD, IN_CHANGED, FAULT, watchdog counter → 0.
- Input synchronisation:
  - IN_PINS passes through a 2-flop synchroniser per bit, running continuously.
  - Pin-to-snapshot latency is 3 cycles.
- Snapshot:
  - Loads the synchroniser output every cycle while STATE != IN.
  - Holds while STATE == IN, so the image is coherent across the whole scan.
- Image write path (combinational, zero latency):
  - IMG_WE = (STATE==IN); IMG_ADDR = COUNT[3:0]; IMG_DIN = snapshot word COUNT[3:0].
  - WR_IMAGE is deliberately ignored: the sequencer's first IN cycle after OUT has WR_IMAGE=0 while COUNT=0.
  - Writes for words 0..15 complete within the IN phase; no write occurs in PROG.
- IN_CHANGED:
  - Registered on the first IN cycle (previous STATE != IN) as (snapshot != last_snapshot).
  - last_snapshot <= snapshot in that same cycle.
  - Value held until the next IN entry.
- Output path:
  - OIMG_ADDR = COUNT[3:0] always (combinational).
  - cap_valid/cap_idx register (STATE==OUT, COUNT[3:0]) each cycle.
  - When cap_valid, staging word cap_idx <= OIMG_DOUT.
  - The cycle after word 15 is captured, OUT_PINS <= staging (or OUT_SAFE if FAULT) and OUT_UPD = 1 for one cycle.
  - Commit latency is 2 cycles after the OUT cycle with COUNT=15, i.e. the second IN cycle.
  - A scan that leaves OUT before index 15 commits nothing.
- Watchdog:
  - Counter increments while STATE==PROG and clears in any other state.
  - On reaching all-ones, FAULT <= 1 (sticky until CLR) and OUT_PINS <= OUT_SAFE immediately.
  - While FAULT is set, every commit drives OUT_SAFE; input scanning continues.
- INIT: snapshot tracks the synchroniser; no image writes, no commits; OUT_PINS holds.
- Reset mid-scan: all state is lost; the next commit requires a complete OUT phase.
- Arithmetic: the watchdog counter is WDOG_W bits unsigned and saturates, with no wrap.

Decomposition:
- Shared package holds:
  - phase encodings ST_INIT/ST_IN/ST_PROG/ST_OUT, common with the sequencer;
  - N_WORDS and the index width (4).
- One sub-module: io_sync, a parameterised-width 2-flop synchroniser with async active-low clear.

Test Plan:
- Drive IN_PINS word k = 16'hA000+k, hold 4 cycles, then IN phase COUNT 0..15 → IMG_WE=1 for 16 cycles, IMG_ADDR=k, IMG_DIN=16'hA000+k.
- Flip IN_PINS word 3 to 16'h5555 mid-IN at COUNT=7 → IMG_DIN for word 3 stays 16'hA003. Next scan writes 16'h5555 and IN_CHANGED=1; a following unchanged scan gives IN_CHANGED=0.
- Output RAM holds 16'h0F00+k; run OUT COUNT 0..15 → OUT_PINS unchanged until the second IN cycle, then all words = 16'h0F00+k together with a single OUT_UPD pulse.
- Hold STATE=PROG for 2^WDOG_W cycles (WDOG_W=6 in bench) → FAULT=1 and OUT_PINS=OUT_SAFE. A following full OUT phase still commits OUT_SAFE.
- Assert CLR=0 asynchronously mid-OUT at COUNT=9 → OUT_PINS=OUT_SAFE and FAULT=0 at once. After release, the partial scan commits nothing; the next full OUT commits.
- STATE=INIT for 32 cycles → IMG_WE=0, OUT_UPD=0, OUT_PINS=OUT_SAFE.
